usb_stream_buffer: RTL and testbench

- Byte-stream buffer between the MUACM USB CDC core and the CPU-side ACIA rx/tx handshake ports.
- Each direction has a synchronous FIFO. Host bursts can therefore arrive while the 6502 is stalled or busy, and CPU output is decoupled from USB packet timing.
- An idle timer asserts a one-cycle flush request to MUACM, so short TX packets are sent promptly.
- Instantiated at top level, between MUACM and cpu_system.

---
 rtl/usb_stream_buffer_pkg.sv | 8 +
 rtl/usb_stream_buffer_stream_fifo.sv | 85 ++++++++
 rtl/usb_stream_buffer.sv | 90 +++++++++
 tb/tb_usb_stream_buffer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/usb_stream_buffer_pkg.sv
// Shared constants for the USB CDC <-> ACIA stream buffer and its FIFOs.
package usb_stream_buffer_pkg;
    localparam int FIFO_AW          = 4;
    localparam int FIFO_DEPTH       = 2 ** FIFO_AW;
    localparam int LEVEL_W          = FIFO_AW + 1;
    localparam int IDLE_CYC_DEFAULT = 1024;
    localparam int IDLE_CNT_W       = 16;
endpackage

// File: rtl/usb_stream_buffer_stream_fifo.sv
// 8-bit synchronous first-word-fall-through FIFO with a registered head,
// a synchronous flush and an occupancy level output.
module stream_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [7:0]    wr_data,
    input  logic          wr_val,
    output logic          wr_rdy,
    output logic [7:0]    rd_data,
    output logic          rd_val,
    input  logic          rd_rdy,
    output logic [AW:0]   level
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic [7:0]    data_q, data_d;
    logic          val_q, val_d, rdy_q, rdy_d;
    logic          push, pop;

    assign push = wr_val & rdy_q;
    assign pop  = rd_rdy & val_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        val_d   = val_q;
        data_d  = data_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            val_d   = 1'b0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            // A fresh push into an idle FIFO shows up one edge late; a pop reloads
            // the head from the post-pop state, bypassing a byte landing in that slot.
            val_d = pop ? (level_d != '0) : (level_q != '0);
            if (val_d)
                data_d = (push && rptr_d == wptr_q) ? wr_data : mem_q[rptr_d];
        end
        rdy_d = (level_d != LEVEL_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            data_q  <= '0;
            val_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            data_q  <= data_d;
            val_q   <= val_d;
            rdy_q   <= rdy_d;
        end
    end

    // NOTE: storage array is deliberately not reset; only pointers/level define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wptr_q] <= wr_data;
    end

    assign wr_rdy  = rdy_q;
    assign rd_data = data_q;
    assign rd_val  = val_q;
    assign level   = level_q;
endmodule

// File: rtl/usb_stream_buffer.sv
// RX/TX byte FIFOs between MUACM and the CPU ACIA ports, plus an idle timer
// that asks MUACM to flush a short TX packet once the CPU stops writing.
module usb_stream_buffer
    import usb_stream_buffer_pkg::*;
#(
    parameter int AW       = FIFO_AW,
    parameter int IDLE_CYC = IDLE_CYC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_val,
    output logic        in_rdy,
    output logic [7:0]  rx_data,
    output logic        rx_val,
    input  logic        rx_rdy,
    input  logic [7:0]  tx_data,
    input  logic        tx_val,
    output logic        tx_rdy,
    output logic [7:0]  out_data,
    output logic        out_val,
    input  logic        out_rdy,
    output logic        usb_flush,
    input  logic        rx_flush,
    input  logic        tx_flush,
    output logic [AW:0] rx_level,
    output logic [AW:0] tx_level
);
    localparam logic [IDLE_CNT_W-1:0] CNT_LAST = IDLE_CNT_W'(IDLE_CYC - 1);

    stream_fifo #(.AW(AW)) u_rx_fifo (
        .clk(clk), .rst(rst), .flush(rx_flush),
        .wr_data(in_data), .wr_val(in_val), .wr_rdy(in_rdy),
        .rd_data(rx_data), .rd_val(rx_val), .rd_rdy(rx_rdy),
        .level(rx_level)
    );

    stream_fifo #(.AW(AW)) u_tx_fifo (
        .clk(clk), .rst(rst), .flush(tx_flush),
        .wr_data(tx_data), .wr_val(tx_val), .wr_rdy(tx_rdy),
        .rd_data(out_data), .rd_val(out_val), .rd_rdy(out_rdy),
        .level(tx_level)
    );

    logic                  sent_q, sent_d;
    logic                  flush_q, flush_d;
    logic [IDLE_CNT_W-1:0] cnt_q, cnt_d;
    logic                  out_xfer;

    assign out_xfer = out_val & out_rdy;

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        sent_d  = sent_q;
        cnt_d   = cnt_q;
        flush_d = 1'b0;
        if (tx_flush) begin
            sent_d = 1'b0;
            cnt_d  = '0;
        end else if (out_xfer) begin
            sent_d = 1'b1;
            cnt_d  = '0;
        end else if (tx_level != '0) begin
            cnt_d = '0;
        end else if (sent_q) begin
            if (cnt_q == CNT_LAST) begin
                flush_d = 1'b1;
                sent_d  = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            sent_q  <= 1'b0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            sent_q  <= sent_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
        end
    end

    assign usb_flush = flush_q;
endmodule

// File: tb/tb_usb_stream_buffer.sv
// Directed self-checking bench for usb_stream_buffer (IDLE_CYC shortened to 8).
module tb_usb_stream_buffer;
    import usb_stream_buffer_pkg::*;

    localparam int AW       = FIFO_AW;
    localparam int IDLE_CYC = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         in_data, tx_data;
    logic               in_val, rx_rdy, tx_val, out_rdy, rx_flush, tx_flush;
    logic               in_rdy, rx_val, tx_rdy, out_val, usb_flush;
    logic [7:0]         rx_data, out_data;
    logic [LEVEL_W-1:0] rx_level, tx_level;

    int n_checks = 0;
    int n_fail   = 0;

    usb_stream_buffer #(.AW(AW), .IDLE_CYC(IDLE_CYC)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_val(in_val), .in_rdy(in_rdy),
        .rx_data(rx_data), .rx_val(rx_val), .rx_rdy(rx_rdy),
        .tx_data(tx_data), .tx_val(tx_val), .tx_rdy(tx_rdy),
        .out_data(out_data), .out_val(out_val), .out_rdy(out_rdy),
        .usb_flush(usb_flush), .rx_flush(rx_flush), .tx_flush(tx_flush),
        .rx_level(rx_level), .tx_level(tx_level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " in_rdy"},    32'(in_rdy),    32'd1);
        check({tag, " tx_rdy"},    32'(tx_rdy),    32'd1);
        check({tag, " rx_val"},    32'(rx_val),    32'd0);
        check({tag, " out_val"},   32'(out_val),   32'd0);
        check({tag, " usb_flush"}, 32'(usb_flush), 32'd0);
        check({tag, " rx_level"},  32'(rx_level),  32'd0);
        check({tag, " tx_level"},  32'(tx_level),  32'd0);
    endtask

    initial begin
        int last_xfer_edge;
        int flush_edge;
        int pulses;
        int n_out;

        rst = 1'b1; in_data = '0; in_val = 1'b0; rx_rdy = 1'b0;
        tx_data = '0; tx_val = 1'b0; out_rdy = 1'b0; rx_flush = 1'b0; tx_flush = 1'b0;

        // Reset state
        step(); step();
        check_reset_state("reset");
        check("reset rx_data",  32'(rx_data),  32'h00);
        check("reset out_data", 32'(out_data), 32'h00);
        rst = 1'b0;
        step();

        // Single RX byte: one cycle of latency before rx_val
        in_data = 8'h41; in_val = 1'b1;
        step();
        in_val = 1'b0;
        check("single rx_val early", 32'(rx_val),   32'd0);
        check("single level early",  32'(rx_level), 32'd1);
        step();
        check("single rx_val",   32'(rx_val),   32'd1);
        check("single rx_data",  32'(rx_data),  32'h41);
        check("single rx_level", 32'(rx_level), 32'd1);
        rx_rdy = 1'b1;
        step();
        rx_rdy = 1'b0;
        check("single pop rx_val",   32'(rx_val),   32'd0);
        check("single pop rx_level", 32'(rx_level), 32'd0);

        // RX fill to full, then drain in order
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            in_data = 8'(i); in_val = 1'b1;
            step();
            if (i == FIFO_DEPTH - 2) check("fill in_rdy before full", 32'(in_rdy), 32'd1);
        end
        in_val = 1'b0;
        check("fill in_rdy full", 32'(in_rdy),   32'd0);
        check("fill rx_level",    32'(rx_level), 32'(FIFO_DEPTH));
        rx_rdy = 1'b1;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            check("drain rx_val",  32'(rx_val),  32'd1);
            check("drain rx_data", 32'(rx_data), 32'(i));
            step();
            if (i == 0) check("drain in_rdy after first pop", 32'(in_rdy), 32'd1);
        end
        rx_rdy = 1'b0;
        check("drain end rx_val",   32'(rx_val),   32'd0);
        check("drain end rx_level", 32'(rx_level), 32'd0);

        // Streaming with wrap: one-byte initial fill, then push+pop every cycle
        in_data = 8'h80; in_val = 1'b1;
        step();
        in_val = 1'b0;
        step();
        rx_rdy = 1'b1; in_val = 1'b1;
        for (int k = 1; k < 40; k++) begin
            in_data = 8'(8'h80 + k);
            check("stream rx_val",  32'(rx_val),  32'd1);
            check("stream rx_data", 32'(rx_data), 32'(8'h80 + k - 1));
            step();
            check("stream level<=1", 32'(rx_level <= 1), 32'd1);
        end
        in_val = 1'b0;
        check("stream last rx_val",  32'(rx_val),  32'd1);
        check("stream last rx_data", 32'(rx_data), 32'(8'h80 + 39));
        step();
        rx_rdy = 1'b0;
        check("stream end rx_val",   32'(rx_val),   32'd0);
        check("stream end rx_level", 32'(rx_level), 32'd0);

        // Flush priority on TX; RX keeps two bytes
        for (int i = 0; i < 5; i++) begin
            tx_data = 8'(8'h10 + i); tx_val = 1'b1;
            in_data = 8'(8'hA1 + i); in_val = (i < 2);
            step();
        end
        tx_val = 1'b0; in_val = 1'b0;
        check("pre-flush tx_level", 32'(tx_level), 32'd5);
        tx_data = 8'h99; tx_val = 1'b1; tx_flush = 1'b1;
        step();
        tx_val = 1'b0; tx_flush = 1'b0;
        check("flush tx_level", 32'(tx_level), 32'd0);
        check("flush out_val",  32'(out_val),  32'd0);
        check("flush tx_rdy",   32'(tx_rdy),   32'd1);
        check("flush rx_level", 32'(rx_level), 32'd2);
        check("flush rx_val",   32'(rx_val),   32'd1);
        check("flush rx_data",  32'(rx_data),  32'hA1);
        tx_data = 8'h55; tx_val = 1'b1;
        step();
        tx_val = 1'b0;
        step();
        check("post-flush out_val",  32'(out_val),  32'd1);
        check("post-flush out_data", 32'(out_data), 32'h55);
        check("post-flush tx_level", 32'(tx_level), 32'd1);
        check("no flush pulse yet",  32'(usb_flush), 32'd0);

        // Reset mid-stream with both FIFOs holding data
        rst = 1'b1;
        step();
        check_reset_state("midreset");
        rst = 1'b0;
        step();

        // Idle flush: 3 TX bytes drained immediately, one pulse IDLE_CYC edges later
        out_rdy = 1'b1;
        last_xfer_edge = -1; flush_edge = -1; pulses = 0; n_out = 0;
        for (int e = 0; e < 40; e++) begin
            tx_val  = (e < 3);
            tx_data = 8'(8'h31 + e);
            if (out_val) begin
                check("idle out_data order", 32'(out_data), 32'(8'h31 + n_out));
                n_out++;
                last_xfer_edge = e + 1;
            end
            step();
            if (usb_flush) begin
                pulses++;
                flush_edge = e + 1;
            end
        end
        tx_val = 1'b0;
        check("idle bytes sent",    32'(n_out),  32'd3);
        check("idle pulse count",   32'(pulses), 32'd1);
        check("idle pulse spacing", 32'(flush_edge - last_xfer_edge), 32'(IDLE_CYC));
        check("idle tx_level",      32'(tx_level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
